// File: rtl/fifo_pkg.sv
// Shared definitions for the write-side FIFO buffer: FSM state encoding and default sizing.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        STORE = 2'd2
    } wr_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 8;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, contents not reset.
module fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_wr_buffer.sv
// Write handshake FSM (IDLE/ACK/STORE) over a circular buffer with show-ahead head word.
// Optional FIFO_ALMOST_FULL_EN adds parameter AF_THRESH and output almost_full.
module fifo_wr_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
`ifdef FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = DEPTH - 2
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              full,
    output logic              empty,
    input  logic              rd_pop,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   count
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    wr_state_e         state;
    logic [DATA_W-1:0] hold_reg;
    logic [ADDR_W-1:0] wptr, rptr;
    logic              store, pop;

    assign store = (state == STORE);
    assign pop   = rd_pop & ~empty;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_THRESH);
    assign almost_full = (count >= AF_CNT);
`endif

    // ready is registered alongside the state so it is a clean Moore output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b0;
            hold_reg <= '0;
            wptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en && !full) begin
                        state    <= ACK;
                        ready    <= 1'b1;
                        hold_reg <= din;
                    end
                end
                ACK: begin
                    if (!wr_en) begin
                        state <= STORE;
                        ready <= 1'b0;
                    end
                end
                STORE: begin
                    state <= IDLE;
                    wptr  <= wptr + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // a slot was reserved at capture time, so store alone can never overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            count <= '0;
        end else begin
            if (pop) rptr <= rptr + 1'b1;
            if (store && !pop)      count <= count + 1'b1;
            else if (!store && pop) count <= count - 1'b1;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (store),
        .waddr (wptr),
        .wdata (hold_reg),
        .raddr (rptr),
        .rdata (dout)
    );

endmodule

// File: doc/fifo_wr_buffer.md
Name: fifo_wr_buffer

Overview:
Write-side handshake controller plus circular storage. It sits directly upstream of the read controller and drives its empty input. A producer presents a word with a level request and waits for ready to be acknowledged; the word is then committed to the buffer. The downstream read controller's load strobe pops the head word, which is always presented show-ahead on dout.

Parameters:
DATA_W, 16, data word width
DEPTH, 8, number of entries (power of two, >=2)
ADDR_W, 3, log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
wr_en  in  1  producer write request (level; held until ready seen, then dropped)
din  in  DATA_W  producer data, must be stable while wr_en high
ready  out  1  write handshake acknowledge (Moore, high only in ACK)
full  out  1  count == DEPTH
empty  out  1  count == 0; feeds read controller's empty input
rd_pop  in  1  pop strobe from read controller (its load pulse), one cycle wide
dout  out  DATA_W  mem[rptr], combinational show-ahead head word
count  out  ADDR_W+1  current occupancy 0..DEPTH

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wptr=rptr=0, count=0, hold_reg=0, ready=0, full=0, empty=1. Memory contents not cleared; dout undefined until first write. Reset asserted mid-handshake aborts it; the partially accepted word is discarded.
- Write FSM, 3 states, registered state, Moore outputs:
  - IDLE: wr_en & ~full -> ACK, capturing din into hold_reg on that edge. wr_en & full -> stay IDLE (request stalls, no ready).
  - ACK: ready=1. wr_en still high -> stay ACK (hold_reg not re-captured). wr_en low -> STORE.
  - STORE: ready=0; on the leaving edge mem[wptr]<=hold_reg, wptr<=wptr+1 (mod DEPTH), count+1; -> IDLE.
  - Minimum 3 cycles per word (IDLE, ACK, STORE). Write visible on dout/empty the cycle after STORE.
- Full is checked only in IDLE. Only STORE increments count, and a slot was free at capture, so STORE never overflows.
- Read side: rd_pop & ~empty -> rptr<=rptr+1 (mod DEPTH), count-1. rd_pop while empty is ignored (no pointer or count change).
- Simultaneous STORE and valid pop in one cycle: both pointers advance, count unchanged, full/empty unchanged.
- Pointers wrap at DEPTH with no extra flag; full/empty are derived from count only.
- full/empty/count are registered-derived (combinational decode of count), with no same-cycle dependence on wr_en/rd_pop.

Optional Feature:
FIFO_ALMOST_FULL_EN: when defined, adds parameter AF_THRESH (default DEPTH-2) and output almost_full (1 bit) = (count >= AF_THRESH), reset 0. When undefined, there is no port and no parameter, and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg: write FSM state encoding (IDLE=2'd0, ACK=2'd1, STORE=2'd2), default DATA_W/DEPTH constants.
- One sub-module fifo_mem: DEPTH x DATA_W array, synchronous write (we, waddr, wdata), asynchronous read (raddr -> rdata), no reset. FSM, pointers and count stay in fifo_wr_buffer.

Test Plan:
- Reset then single write of din=16'hA5A5 (wr_en high 2 cycles, then low) -> ready high 2 cycles, STORE 1 cycle, then empty=0, count=1, dout=16'hA5A5.
- 8 back-to-back writes 1..8 -> full=1, count=8; a 9th wr_en held 5 cycles -> ready stays 0, state IDLE; one rd_pop -> next IDLE cycle enters ACK.
- Fill with 1..8, pop 8 times -> dout sequence 1..8, then empty=1; an extra rd_pop leaves count=0 and rptr unchanged.
- Wrap: write 6, pop 6, write 5 -> wptr wraps to 3, dout order preserved, count=5.
- STORE coincident with rd_pop at count=3 -> count stays 3, both pointers advance by 1.
- rst_n pulled low while in ACK with hold_reg=16'h1234 -> immediate ready=0, empty=1, count=0; after release, that word never appears on dout.
